ysyx_25020047_lsu: RTL

YSYX_25020047_LSU -- requirements
Module: ysyx_25020047_lsu

---
 rtl/ysyx_25020047_pkg.sv | 26 ++
 rtl/ysyx_25020047_lsu_if.sv | 41 ++++
 rtl/ysyx_25020047_lsu_align.sv | 42 ++++
 rtl/ysyx_25020047_lsu.sv | 117 +++++++++++
 4 files changed

// File: rtl/ysyx_25020047_pkg.sv
// Shared types for the load/store unit: FSM states, access size codes and the
// alignment rule used to reject ops before they reach the memory bus.
package ysyx_25020047_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } lsu_size_t;

  localparam int CNT_W = 16;

  // Halves must sit on even addresses, words on multiples of four.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    return ((size == SZ_HALF) && offset[0]) || ((size == SZ_WORD) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_25020047_lsu_if.sv
// Bundle of the EXU-side op handshake, the memory request/response bus and the
// completion outputs. The LSU takes the slave view; the environment the master.
interface ysyx_25020047_lsu_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        read;
  logic        write;
  logic [1:0]  size;
  logic        sext;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  logic        done;
  logic [31:0] load_data;
  logic        err;

  modport slave (
    input  in_valid, addr, wdata, read, write, size, sext,
           mem_req_ready, mem_rsp_valid, mem_rdata,
    output in_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
           done, load_data, err
  );

  modport master (
    output in_valid, addr, wdata, read, write, size, sext,
           mem_req_ready, mem_rsp_valid, mem_rdata,
    input  in_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
           done, load_data, err
  );

endinterface

// File: rtl/ysyx_25020047_lsu_align.sv
// Byte-lane steering: store strobes and data shifted into their lanes, and load
// data shifted down, truncated to the access size and zero/sign extended.
module ysyx_25020047_lsu_align
  import ysyx_25020047_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        write,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        sext,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [31:0] rdata_sh;

  assign wdata_sh = wdata << {offset, 3'b000};
  assign rdata_sh = rdata >> {offset, 3'b000};

  always_comb begin
    wmask = 4'b0000;
    if (write) begin
      case (size)
        SZ_BYTE: wmask = 4'b0001 << offset;
        SZ_HALF: wmask = 4'b0011 << offset;
        SZ_WORD: wmask = 4'b1111;
        default: wmask = 4'b0000;
      endcase
    end
  end

  always_comb begin
    case (size)
      SZ_BYTE: rdata_ext = {{24{sext & rdata_sh[7]}}, rdata_sh[7:0]};
      SZ_HALF: rdata_ext = {{16{sext & rdata_sh[15]}}, rdata_sh[15:0]};
      default: rdata_ext = rdata_sh;
    endcase
  end

endmodule

// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: accepts one EXU op at a time, screens out non-memory and
// illegal ops, then runs a single request/response transaction with a timeout.
module ysyx_25020047_lsu
  import ysyx_25020047_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  ysyx_25020047_lsu_if.slave bus
);

  lsu_state_t        state;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic              read_q;
  logic              write_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nx;
  logic              err_q;
  logic [31:0]       load_q;
  logic              bad_op;
  logic [3:0]        wmask;
  logic [31:0]       wdata_sh;
  logic [31:0]       rdata_ext;

  ysyx_25020047_lsu_align u_align (
    .offset    (addr_q[1:0]),
    .size      (size_q),
    .write     (write_q),
    .wdata     (wdata_q),
    .rdata     (bus.mem_rdata),
    .sext      (sext_q),
    .wmask     (wmask),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext)
  );

  assign bad_op   = (bus.read && bus.write) || (bus.size == SZ_RSVD) ||
                    misaligned(bus.size, bus.addr[1:0]);
  assign count_nx = count + 1'b1;

  assign bus.in_ready      = (state == IDLE);
  assign bus.mem_req_valid = (state == REQ);
  assign bus.mem_addr      = {addr_q[31:2], 2'b00};
  assign bus.mem_wen       = write_q;
  assign bus.mem_wdata     = wdata_sh;
  assign bus.mem_wmask     = wmask;
  assign bus.done          = (state == DONE);
  assign bus.err           = err_q;
  assign bus.load_data     = load_q;

  // Ops with neither read nor write complete immediately as a pass-through,
  // even if their size/address fields would otherwise be illegal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      count   <= '0;
      err_q   <= 1'b0;
      load_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            read_q  <= bus.read;
            write_q <= bus.write;
            size_q  <= bus.size;
            sext_q  <= bus.sext;
            if (!bus.read && !bus.write) begin
              state  <= DONE;
              err_q  <= 1'b0;
              load_q <= '0;
            end else if (bad_op) begin
              state  <= DONE;
              err_q  <= 1'b1;
              load_q <= '0;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            state <= WAIT;
            count <= '0;
          end
        end
        WAIT: begin
          if (bus.mem_rsp_valid) begin
            state  <= DONE;
            err_q  <= 1'b0;
            load_q <= read_q ? rdata_ext : 32'h0;
          end else if (count_nx == CNT_W'(TIMEOUT)) begin
            state  <= DONE;
            err_q  <= 1'b1;
            load_q <= '0;
          end else begin
            count <= count_nx;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
